// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU (A) and load (B) writebacks, optional post-reset clear.
// Latency: a grant in cycle N appears on rf_we/rf_waddr/rf_wdata after the posedge ending cycle N (1 cycle).
// Backpressure: a_ready/b_ready are combinational grants; losers and requests during CLEAR hold until accepted.
// Optional feature: define RF_CLEAR_EN to zero registers 0..31 after reset before accepting writes.
module rf_write_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_we,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

`ifdef RF_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    state_t state;
    state_t state_nxt;

    // prio_b set means A won the last grant, so B wins the next tie.
    logic prio_b;
    logic grant_a;
    logic grant_b;
    logic stall_ev;

`ifdef RF_CLEAR_EN
    logic [4:0] clr_cnt;
`endif

    // Next state and grant decision; no grants outside RUN.
    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        case (state)
            CLEAR: begin
`ifdef RF_CLEAR_EN
                if (clr_cnt == 5'd31) begin
                    state_nxt = RUN;
                end
`else
                state_nxt = RUN;
`endif
            end
            RUN: begin
                grant_a = a_valid & (~b_valid | ~prio_b);
                grant_b = b_valid & (~a_valid |  prio_b);
            end
            default: state_nxt = RESET_STATE;
        endcase
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;

    // A stall is any cycle in RUN where some valid requester lost; two losers still count once.
    assign stall_ev = (state == RUN) & ((a_valid & ~grant_a) | (b_valid & ~grant_b));

`ifdef RF_CLEAR_EN
    assign busy = (state == CLEAR);
`else
    assign busy = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin pointer follows the most recent winner; holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_b <= 1'b0;
        end else if (grant_a) begin
            prio_b <= 1'b1;
        end else if (grant_b) begin
            prio_b <= 1'b0;
        end
    end

`ifdef RF_CLEAR_EN
    // Clear address counter walks 0..31 while in CLEAR and wraps back to 0 on exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt <= 5'd0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 5'd1;
        end
    end
`endif

    // Registered write port: granted request, clear write, or idle (address/data hold).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (grant_a) begin
            rf_we    <= 1'b1;
            rf_waddr <= a_addr;
            rf_wdata <= a_data;
        end else if (grant_b) begin
            rf_we    <= 1'b1;
            rf_waddr <= b_addr;
            rf_wdata <= b_data;
`ifdef RF_CLEAR_EN
        end else if (state == CLEAR) begin
            rf_we    <= 1'b1;
            rf_waddr <= clr_cnt;
            rf_wdata <= 32'd0;
`endif
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (stall_ev && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// The model tracks which requester won last and what the write port should show after each edge.
// Builds with or without RF_CLEAR_EN; clear-sequence scenarios only exist in the RF_CLEAR_EN build.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic        busy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    byte         last_winner;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    int          exp_stall;
    logic        exp_ga;
    logic        exp_gb;
    logic        obs_ar;
    logic        obs_br;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_we     (rf_we),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    function automatic void model_reset();
        last_winner = "B";
        exp_we      = 1'b0;
        exp_waddr   = 5'd0;
        exp_wdata   = 32'd0;
        exp_stall   = 0;
    endfunction

    // One arbitration cycle: drive at negedge, sample readies, model the edge, settle after posedge.
    task automatic run_cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                             input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        obs_ar = a_ready;
        obs_br = b_ready;
        exp_ga = 1'b0;
        exp_gb = 1'b0;
        if (av && bv) begin
            if (last_winner == "A") exp_gb = 1'b1;
            else                    exp_ga = 1'b1;
        end else if (av) begin
            exp_ga = 1'b1;
        end else if (bv) begin
            exp_gb = 1'b1;
        end
        @(posedge clk);
        if (exp_ga) begin
            last_winner = "A"; exp_we = 1'b1; exp_waddr = aa; exp_wdata = ad;
        end else if (exp_gb) begin
            last_winner = "B"; exp_we = 1'b1; exp_waddr = ba; exp_wdata = bd;
        end else begin
            exp_we = 1'b0;
        end
        if ((av && !exp_ga) || (bv && !exp_gb))
            exp_stall = (exp_stall < 65535) ? exp_stall + 1 : 65535;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Waits out the post-reset clear (bounded) and aligns the model with its last write.
    task automatic wait_run();
`ifdef RF_CLEAR_EN
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_timeout: busy=%b required 0", busy);
        end
        exp_we = 1'b1; exp_waddr = 5'd31; exp_wdata = 32'd0;
`endif
    endtask

    task automatic test_reset();
        logic exp_busy;
`ifdef RF_CLEAR_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        checks += 6;
        if (rf_we !== 1'b0)     begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
        if (rf_waddr !== 5'd0)  begin errors++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
        if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        if (busy !== exp_busy)  begin errors++; $display("FAIL reset_busy: got %b want %b", busy, exp_busy); end
        if (a_ready !== 1'b0)   begin errors++; $display("FAIL reset_aready: got %b want 0", a_ready); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        wait_run();
        run_cycle(1'b1, 5'd12, 32'h55, 1'b0, 5'd0, 32'd0);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        run_cycle(1'b1, 5'd13, 32'h66, 1'b0, 5'd0, 32'd0);
        // Reset mid-cycle must clear the pending write immediately.
        #2;
        reset = 1'b1;
        #1;
        checks += 2;
        if (rf_we !== 1'b0)    begin errors++; $display("FAIL async_reset_we: got %b want 0", rf_we); end
        if (rf_waddr !== 5'd0) begin errors++; $display("FAIL async_reset_waddr: got %0d want 0", rf_waddr); end
        apply_reset();
    endtask

    task automatic test_a_only();
        apply_reset();
        wait_run();
        run_cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        checks += 5;
        if (obs_ar !== 1'b1)     begin errors++; $display("FAIL a_only_ready: got %b want 1", obs_ar); end
        if (obs_br !== 1'b0)     begin errors++; $display("FAIL a_only_bready: got %b want 0", obs_br); end
        if (rf_we !== 1'b1)      begin errors++; $display("FAIL a_only_we: got %b want 1", rf_we); end
        if (rf_waddr !== 5'd5)   begin errors++; $display("FAIL a_only_waddr: got %0d want 5", rf_waddr); end
        if (rf_wdata !== 32'h11) begin errors++; $display("FAIL a_only_wdata: got %h want 11", rf_wdata); end
    endtask

    task automatic test_both();
        logic        want_a;
        logic [4:0]  want_addr;
        apply_reset();
        wait_run();
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
            want_a    = (i % 2 == 0);
            want_addr = want_a ? 5'd3 : 5'd7;
            checks += 4;
            if (obs_ar !== want_a)  begin errors++; $display("FAIL both_aready[%0d]: got %b want %b", i, obs_ar, want_a); end
            if (obs_br !== !want_a) begin errors++; $display("FAIL both_bready[%0d]: got %b want %b", i, obs_br, !want_a); end
            if (rf_waddr !== want_addr) begin errors++; $display("FAIL both_waddr[%0d]: got %0d want %0d", i, rf_waddr, want_addr); end
            if (stall_cnt !== 16'(i + 1)) begin errors++; $display("FAIL both_stall[%0d]: got %0d want %0d", i, stall_cnt, i + 1); end
        end
    endtask

    task automatic test_idle();
        run_cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        checks++;
        if (rf_waddr !== 5'd9) begin errors++; $display("FAIL idle_write: got %0d want 9", rf_waddr); end
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            checks += 4;
            if (rf_we !== 1'b0)      begin errors++; $display("FAIL idle_we[%0d]: got %b want 0", i, rf_we); end
            if (rf_waddr !== 5'd9)   begin errors++; $display("FAIL idle_waddr[%0d]: got %0d want 9", i, rf_waddr); end
            if (rf_wdata !== 32'h99) begin errors++; $display("FAIL idle_wdata[%0d]: got %h want 99", i, rf_wdata); end
            if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL idle_stall[%0d]: got %0d want %0d", i, stall_cnt, exp_stall); end
        end
    endtask

    task automatic test_addr0();
        run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        checks += 4;
        if (obs_br !== 1'b1)       begin errors++; $display("FAIL addr0_bready: got %b want 1", obs_br); end
        if (rf_we !== 1'b1)        begin errors++; $display("FAIL addr0_we: got %b want 1", rf_we); end
        if (rf_waddr !== 5'd0)     begin errors++; $display("FAIL addr0_waddr: got %0d want 0", rf_waddr); end
        if (rf_wdata !== 32'hDEAD) begin errors++; $display("FAIL addr0_wdata: got %h want dead", rf_wdata); end
    endtask

    task automatic test_random();
        logic        ap, bp;
        logic [4:0]  aa, ba;
        logic [31:0] ad, bd;
        ap = 1'b0; bp = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!ap) begin
                ap = ($urandom_range(0, 2) != 0);
                aa = 5'($urandom);
                ad = $urandom;
            end
            if (!bp) begin
                bp = ($urandom_range(0, 2) != 0);
                ba = 5'($urandom);
                bd = $urandom;
            end
            run_cycle(ap, aa, ad, bp, ba, bd);
            checks += 4;
            if (obs_ar !== exp_ga) begin errors++; $display("FAIL rand_aready[%0d]: got %b want %b", i, obs_ar, exp_ga); end
            if (obs_br !== exp_gb) begin errors++; $display("FAIL rand_bready[%0d]: got %b want %b", i, obs_br, exp_gb); end
            if (rf_we !== exp_we)  begin errors++; $display("FAIL rand_we[%0d]: got %b want %b", i, rf_we, exp_we); end
            if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL rand_stall[%0d]: got %0d want %0d", i, stall_cnt, exp_stall); end
            if (exp_we) begin
                checks++;
                if (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
                    errors++;
                    $display("FAIL rand_write[%0d]: got %0d/%h want %0d/%h", i, rf_waddr, rf_wdata, exp_waddr, exp_wdata);
                end
            end
            if (exp_ga) ap = 1'b0;
            if (exp_gb) bp = 1'b0;
        end
    endtask

`ifdef RF_CLEAR_EN
    task automatic test_clear();
        @(negedge clk);
        reset = 1'b1;
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44; b_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 32; k++) begin
            #1;
            checks += 2;
            if (busy !== 1'b1)    begin errors++; $display("FAIL clear_busy[%0d]: got %b want 1", k, busy); end
            if (a_ready !== 1'b0) begin errors++; $display("FAIL clear_aready[%0d]: got %b want 0", k, a_ready); end
            @(posedge clk);
            #1;
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'd0) begin
                errors++;
                $display("FAIL clear_write[%0d]: got we=%b %0d/%h want we=1 %0d/0", k, rf_we, rf_waddr, rf_wdata, k);
            end
            @(negedge clk);
        end
        #1;
        checks += 2;
        if (busy !== 1'b0)    begin errors++; $display("FAIL clear_done_busy: got %b want 0", busy); end
        if (a_ready !== 1'b1) begin errors++; $display("FAIL clear_first_grant: got %b want 1", a_ready); end
        @(posedge clk);
        #1;
        checks += 2;
        if (rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin errors++; $display("FAIL clear_a_write: got %0d/%h want 4/44", rf_waddr, rf_wdata); end
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL clear_stall: got %0d want 0", stall_cnt); end
        // Abort a clear part-way and confirm it restarts from address 0.
        apply_reset();
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL clear_abort_we: got %b want 0", rf_we); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd0) begin errors++; $display("FAIL clear_restart: got we=%b addr=%0d want we=1 addr=0", rf_we, rf_waddr); end
        wait_run();
    endtask
`endif

    task automatic test_saturate();
        apply_reset();
        wait_run();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2;
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_before: got %h want fffe", stall_cnt); end
        @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", stall_cnt); end
        repeat (4465) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_a_only();
        test_both();
        test_idle();
        test_addr0();
        test_random();
`ifdef RF_CLEAR_EN
        test_clear();
`endif
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
